ospfb_capture_ctrl: RTL and testbench

Run controller for the ADC → OSPFB → capture-VIP chain. It gates the ADC valid enable and waits out a configurable number of settling output frames while the PFB/FFT pipeline fills. It then opens the capture gate for exactly CAP_FRAMES output frames and latches any FFT status events as sticky faults. The block sits on the DSP clock domain, next to the OSPFB instance, and drives the ADC `en` and the capture tvalid qualifier.

---
 rtl/ospfb_capture_ctrl.sv | 152 +++++++++++++++
 tb/tb_ospfb_capture_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ospfb_capture_ctrl.sv
`timescale 1ns/1ps
// Run controller for the ADC -> OSPFB -> capture chain: enables the ADC, discards settle
// frames, gates exactly CAP_FRAMES frames to capture and latches FFT status events.
module ospfb_capture_ctrl #(
  parameter int FFT_LEN       = 64,
  parameter int SAMP_PER_CLK  = 2,
  parameter int SETTLE_FRAMES = 4,
  parameter int CAP_FRAMES    = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             xk_tvalid,
  input  logic             xk_tready,
  input  logic             xk_tlast,
  input  logic [1:0]       ev_frame_started,
  input  logic [1:0]       ev_tlast_unexpected,
  input  logic [1:0]       ev_tlast_missing,
  input  logic [1:0]       ev_fft_overflow,
  input  logic [1:0]       ev_data_in_halt,
  output logic             adc_en,
  output logic             cap_en,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [4:0]       err_sticky,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BEATS = FFT_LEN / SAMP_PER_CLK;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]    BEAT_MAX    = BW'(BEATS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CAP_LAST    = CNT_W'(CAP_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SETTLE, S_CAPTURE, S_DONE, S_FAULT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [BW-1:0]    r_beat_cnt;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_nxt, w_frame_inc;
  logic [4:0]       r_err_sticky, w_err_nxt, w_err_evt;
  logic             r_adc_en, r_cap_en, r_busy, r_done, r_fault;
  logic             w_beat, w_eof, w_len_err, w_ev_fault, w_active, w_nxt_active, w_beat_clr;

  assign w_beat    = xk_tvalid & xk_tready;
  assign w_eof     = w_beat & xk_tlast;
  assign w_len_err = (w_eof & (r_beat_cnt != BEAT_MAX)) |
                     (w_beat & ~xk_tlast & (r_beat_cnt == BEAT_MAX));
  assign w_active  = (r_state == S_ARM) | (r_state == S_SETTLE) | (r_state == S_CAPTURE);

  // In ARM no frame boundary is expected yet, so any tlast counts as a length error.
  assign w_err_evt   = {|ev_data_in_halt, |ev_fft_overflow, |ev_tlast_missing,
                        |ev_tlast_unexpected, w_len_err | ((r_state == S_ARM) & w_eof)};
  assign w_ev_fault  = |w_err_evt[4:1];
  assign w_frame_inc = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame_cnt;
    w_err_nxt   = r_err_sticky;
    w_beat_clr  = 1'b0;
    if (w_active) w_err_nxt = r_err_sticky | w_err_evt;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_frame_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            w_state_nxt = S_ARM;
            w_frame_nxt = '0;
            w_err_nxt   = '0;
            w_beat_clr  = 1'b1;
          end
        end
        S_ARM: begin
          if (|ev_frame_started) begin
            w_state_nxt = S_SETTLE;
            w_frame_nxt = '0;
            w_beat_clr  = 1'b1;
          end
        end
        S_SETTLE: begin
          if (w_ev_fault) begin
            w_state_nxt = S_FAULT;
          end else if (w_eof) begin
            if (r_frame_cnt == SETTLE_LAST) begin
              w_state_nxt = S_CAPTURE;
              w_frame_nxt = '0;
            end else begin
              w_frame_nxt = w_frame_inc;
            end
          end
        end
        S_CAPTURE: begin
          if (w_ev_fault | w_len_err) begin
            w_state_nxt = S_FAULT;
          end else if (w_eof) begin
            if (r_frame_cnt == CAP_LAST) w_state_nxt = S_DONE;
            else                         w_frame_nxt = w_frame_inc;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_nxt_active = (w_state_nxt == S_ARM) | (w_state_nxt == S_SETTLE) |
                        (w_state_nxt == S_CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_frame_cnt  <= '0;
      r_err_sticky <= '0;
      r_adc_en     <= 1'b0;
      r_cap_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_cnt  <= w_frame_nxt;
      r_err_sticky <= w_err_nxt;
      r_adc_en     <= w_nxt_active;
      r_cap_en     <= (w_state_nxt == S_CAPTURE);
      r_busy       <= w_nxt_active;
      r_done       <= (w_state_nxt == S_DONE);
      r_fault      <= (w_state_nxt == S_FAULT);
    end
  end

  // Saturates on an over-long frame so every further non-last beat keeps flagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_beat_cnt <= '0;
    else if (w_beat_clr | w_eof)               r_beat_cnt <= '0;
    else if (w_beat && r_beat_cnt != BEAT_MAX) r_beat_cnt <= r_beat_cnt + BW'(1);
  end

  assign adc_en     = r_adc_en;
  assign cap_en     = r_cap_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign fault      = r_fault;
  assign err_sticky = r_err_sticky;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ospfb_capture_ctrl.sv
`timescale 1ns/1ps
// Bench for ospfb_capture_ctrl: directed run scenarios plus a random soak, every cycle
// compared against a phase-level reference model of the run controller.
module tb_ospfb_capture_ctrl;

  localparam int FFT_LEN = 64, SPC = 2, SETTLE = 4, CAP = 2, CNT_W = 16;
  localparam int BEATS = FFT_LEN / SPC;
  localparam int P_IDLE = 0, P_ARM = 1, P_SETTLE = 2, P_CAPTURE = 3, P_DONE = 4, P_FAULT = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, abort = 0, xk_tvalid = 0, xk_tready = 0, xk_tlast = 0;
  logic [1:0] ev_frame_started = 0, ev_tlast_unexpected = 0, ev_tlast_missing = 0;
  logic [1:0] ev_fft_overflow = 0, ev_data_in_halt = 0;
  logic adc_en, cap_en, busy, done, fault;
  logic [4:0] err_sticky;
  logic [CNT_W-1:0] frame_cnt;

  int checks = 0, errors = 0, gated = 0;
  int m_phase, m_frames, m_pos;
  logic [4:0] m_sticky;

  always #5 clk = ~clk;

  ospfb_capture_ctrl #(.FFT_LEN(FFT_LEN), .SAMP_PER_CLK(SPC), .SETTLE_FRAMES(SETTLE),
                       .CAP_FRAMES(CAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .xk_tvalid(xk_tvalid), .xk_tready(xk_tready), .xk_tlast(xk_tlast),
    .ev_frame_started(ev_frame_started), .ev_tlast_unexpected(ev_tlast_unexpected),
    .ev_tlast_missing(ev_tlast_missing), .ev_fft_overflow(ev_fft_overflow),
    .ev_data_in_halt(ev_data_in_halt),
    .adc_en(adc_en), .cap_en(cap_en), .busy(busy), .done(done), .fault(fault),
    .err_sticky(err_sticky), .frame_cnt(frame_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_frames = 0; m_pos = 0; m_sticky = '0;
  endtask

  // One clock of the run rules, evaluated on the inputs present at the edge.
  task automatic model_step();
    bit beat, eof, lbad, run;
    logic [4:0] ev;
    int nph, nfr, npos, lim;
    if (!rst_n) begin model_reset(); return; end
    beat = xk_tvalid && xk_tready;
    eof  = beat && xk_tlast;
    lbad = (eof && m_pos != BEATS - 1) || (beat && !xk_tlast && m_pos == BEATS - 1);
    run  = (m_phase == P_ARM) || (m_phase == P_SETTLE) || (m_phase == P_CAPTURE);
    ev   = {|ev_data_in_halt, |ev_fft_overflow, |ev_tlast_missing, |ev_tlast_unexpected,
            lbad || (m_phase == P_ARM && eof)};
    nph = m_phase; nfr = m_frames;
    npos = eof ? 0 : ((beat && m_pos < BEATS - 1) ? m_pos + 1 : m_pos);
    if (run) m_sticky = m_sticky | ev;
    if (abort) begin
      nph = P_IDLE; nfr = 0;
    end else if (!run) begin
      if (start) begin nph = P_ARM; nfr = 0; m_sticky = '0; end
    end else if (m_phase == P_ARM) begin
      if (|ev_frame_started) begin nph = P_SETTLE; nfr = 0; end
    end else begin
      lim = (m_phase == P_SETTLE) ? SETTLE : CAP;
      if (ev[4:1] != 0 || (m_phase == P_CAPTURE && lbad)) nph = P_FAULT;
      else if (eof) begin
        if (m_frames == lim - 1) begin
          nph = (m_phase == P_SETTLE) ? P_CAPTURE : P_DONE;
          nfr = (m_phase == P_SETTLE) ? 0 : m_frames;
        end else begin
          nfr = (m_frames == (1 << CNT_W) - 1) ? m_frames : m_frames + 1;
        end
      end
    end
    if (nph != m_phase && (nph == P_ARM || nph == P_SETTLE)) npos = 0;
    m_phase = nph; m_frames = nfr; m_pos = npos;
  endtask

  task automatic compare_all();
    bit run;
    run = (m_phase == P_ARM) || (m_phase == P_SETTLE) || (m_phase == P_CAPTURE);
    check("adc_en", adc_en, run);
    check("cap_en", cap_en, m_phase == P_CAPTURE);
    check("busy", busy, run);
    check("done", done, m_phase == P_DONE);
    check("fault", fault, m_phase == P_FAULT);
    check("err_sticky", err_sticky, m_sticky);
    check("frame_cnt", frame_cnt, m_frames);
  endtask

  task automatic cycle();
    if (cap_en && xk_tvalid && xk_tready) gated++;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_start();
    start = 1; cycle(); start = 0;
  endtask

  task automatic pulse_fs(input int gap);
    for (int i = 0; i < gap; i++) cycle();
    ev_frame_started = 2'b01; cycle(); ev_frame_started = 0;
  endtask

  // Frame whose tlast lands on beat nbeats; rnd_rdy randomises tready.
  task automatic send_frame(input int nbeats, input bit rnd_rdy);
    int k = 0;
    while (k < nbeats) begin
      xk_tvalid = 1;
      xk_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      xk_tlast  = (k == nbeats - 1);
      cycle();
      if (xk_tvalid && xk_tready) k++;
    end
    xk_tvalid = 0; xk_tlast = 0;
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      xk_tvalid = 1; xk_tready = 1; xk_tlast = 0; cycle();
    end
    xk_tvalid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_adc_en", adc_en, 0);
    check("rst_busy", busy, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk); rst_n = 1;

    // Nominal run.
    cycle();
    pulse_start();
    check("s1_adc_rise", adc_en, 1);
    pulse_fs(10);
    for (int f = 0; f < 3; f++) send_frame(BEATS, 0);
    check("s1_cap_before", cap_en, 0);
    send_frame(BEATS, 0);
    check("s1_cap_rise", cap_en, 1);
    send_frame(BEATS, 0);
    check("s1_cap_hold", cap_en, 1);
    send_frame(BEATS, 0);
    check("s1_cap_fall", cap_en, 0);
    check("s1_done", done, 1);
    check("s1_sticky", err_sticky, 0);

    // Backpressure during capture.
    pulse_start();
    pulse_fs(3);
    for (int f = 0; f < SETTLE; f++) send_frame(BEATS, 0);
    gated = 0;
    for (int f = 0; f < CAP; f++) send_frame(BEATS, 1);
    cycle();
    check("s2_gated_beats", gated, 64);
    check("s2_frame_cnt", frame_cnt, 1);
    check("s2_done", done, 1);

    // Overflow event during capture.
    pulse_start();
    pulse_fs(2);
    for (int f = 0; f < SETTLE; f++) send_frame(BEATS, 0);
    send_beats(5);
    ev_fft_overflow = 2'b10; cycle(); ev_fft_overflow = 0;
    check("s3_fault", fault, 1);
    check("s3_sticky", err_sticky, 5'b01000);
    check("s3_adc_en", adc_en, 0);
    check("s3_cap_en", cap_en, 0);

    // Short frame in capture faults; in settle it is only recorded.
    pulse_start();
    pulse_fs(2);
    for (int f = 0; f < SETTLE; f++) send_frame(BEATS, 0);
    send_frame(20, 0);
    check("s4_cap_fault", fault, 1);
    check("s4_cap_sticky", err_sticky, 5'b00001);
    pulse_start();
    pulse_fs(2);
    send_frame(20, 0);
    check("s4_settle_nofault", fault, 0);
    for (int f = 0; f < SETTLE - 1 + CAP; f++) send_frame(BEATS, 0);
    check("s4_settle_done", done, 1);
    check("s4_settle_sticky", err_sticky, 5'b00001);

    // Abort together with an eof in settle, then a clean re-run.
    pulse_start();
    pulse_fs(2);
    send_frame(BEATS, 0); send_frame(BEATS, 0);
    send_beats(BEATS - 1);
    xk_tvalid = 1; xk_tready = 1; xk_tlast = 1; abort = 1;
    cycle();
    xk_tvalid = 0; xk_tlast = 0; abort = 0;
    check("s5_adc_en", adc_en, 0);
    check("s5_frame_cnt", frame_cnt, 0);
    check("s5_busy", busy, 0);
    pulse_start();
    pulse_fs(4);
    for (int f = 0; f < SETTLE + CAP; f++) send_frame(BEATS, 0);
    check("s5_rerun_done", done, 1);
    check("s5_rerun_sticky", err_sticky, 0);

    // Asynchronous reset in the middle of capture.
    pulse_start();
    pulse_fs(2);
    for (int f = 0; f < SETTLE; f++) send_frame(BEATS, 0);
    send_beats(10);
    #2 rst_n = 0;
    #1;
    check("s6_adc_en", adc_en, 0);
    check("s6_cap_en", cap_en, 0);
    check("s6_busy", busy, 0);
    check("s6_frame_cnt", frame_cnt, 0);
    model_reset();
    cycle(); cycle();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      xk_tvalid = 1'($urandom_range(0, 1)); xk_tready = 1; xk_tlast = 1'($urandom_range(0, 1));
      cycle();
    end
    check("s6_no_done", done, 0);
    check("s6_no_fault", fault, 0);

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 399) == 0);
      ev_frame_started    = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ev_tlast_unexpected = ($urandom_range(0, 499) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ev_tlast_missing    = ($urandom_range(0, 499) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ev_fft_overflow     = ($urandom_range(0, 499) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ev_data_in_halt     = ($urandom_range(0, 499) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      xk_tvalid = ($urandom_range(0, 7) != 0);
      xk_tready = ($urandom_range(0, 7) != 0);
      xk_tlast  = (m_pos == BEATS - 1) ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 99) == 0);
      cycle();
    end
    start = 0; abort = 0; ev_frame_started = 0; ev_tlast_unexpected = 0;
    ev_tlast_missing = 0; ev_fft_overflow = 0; ev_data_in_halt = 0;
    xk_tvalid = 0; xk_tlast = 0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
